// File: rtl/mrv1_pkg.sv
// rtl/mrv1_pkg.sv - shared types and helpers for the mrv1 fetch path
//
// Purpose: fetch queue entry layout, RV32 opcode marker and the
// instruction-length helper used by the fetch aligner.
// Ports: none (package).

package mrv1_pkg;

  localparam int MRV_TWID_WIDTH_C = 2;

  // Low two bits of a halfword equal to this mark a 32-bit instruction.
  localparam logic [1:0] MRV_INSN_RV32_OPC_C = 2'b11;

  typedef struct packed {
    logic [31:0]                 data;
    logic [31:0]                 pc;      // word aligned, [1:0] = 0
    logic [MRV_TWID_WIDTH_C-1:0] twid;
    logic                        skip_lo; // lower halfword is not part of the stream
  } mrv_fetch_entry_t;

  function automatic logic is_rv32(input logic [15:0] hw);
    return hw[1:0] == MRV_INSN_RV32_OPC_C;
  endfunction

endpackage

// File: rtl/mrv1_fetch_fifo.sv
// rtl/mrv1_fetch_fifo.sv - circular FIFO of fetch queue entries
//
// Purpose: DEPTH_P-entry queue of mrv_fetch_entry_t with synchronous flush.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         empties the queue at the next edge; a same-cycle push is dropped
//   push_i          write push_data_i (ignored when full)
//   push_data_i     entry to write
//   pop_i           retire the head entry (ignored when empty)
//   head_o          current head entry
//   full_o, empty_o occupancy flags

module mrv1_fetch_fifo
  import mrv1_pkg::*;
#(
  parameter int DEPTH_P = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  mrv_fetch_entry_t push_data_i,
  input  logic             pop_i,
  output mrv_fetch_entry_t head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH_P);

  // One extra pointer bit distinguishes full from empty.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  mrv_fetch_entry_t mem_q [DEPTH_P];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mrv1_ifetch_align.sv
// rtl/mrv1_ifetch_align.sv - fetch word queue and RV32/RVC instruction aligner
//
// Purpose: buffers 32-bit fetch words and emits one raw RV32 or RVC
// instruction per cycle, including 32-bit instructions straddling words.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       redirect, drops all buffered state
//   fetch_vld_i/fetch_rdy_o       fetch word handshake
//   fetch_data_i/pc_i/twid_i      fetch word, PC of first useful halfword, thread
//   insn_vld_o/insn_rdy_i         instruction handshake to decode
//   insn_o/insn_pc_o/insn_twid_o  instruction (RVC zero-extended), PC, thread

module mrv1_ifetch_align
  import mrv1_pkg::*;
#(
  parameter int DATA_WIDTH_P = 32,
  parameter int DEPTH_P      = 4,
  parameter int TWID_WIDTH_P = MRV_TWID_WIDTH_C
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    fetch_vld_i,
  output logic                    fetch_rdy_o,
  input  logic [DATA_WIDTH_P-1:0] fetch_data_i,
  input  logic [31:0]             fetch_pc_i,
  input  logic [TWID_WIDTH_P-1:0] fetch_twid_i,
  output logic                    insn_vld_o,
  input  logic                    insn_rdy_i,
  output logic [DATA_WIDTH_P-1:0] insn_o,
  output logic [31:0]             insn_pc_o,
  output logic [TWID_WIDTH_P-1:0] insn_twid_o
);

  mrv_fetch_entry_t push_entry;
  mrv_fetch_entry_t head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             unused_pc_bit0;

  // Aligner state: halfword offset into the head word, plus the low half
  // of a straddling 32-bit instruction waiting for its upper half.
  logic                    off_q, off_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [15:0]             hold_data_q, hold_data_d;
  logic [31:0]             hold_pc_q, hold_pc_d;
  logic [TWID_WIDTH_P-1:0] hold_twid_q, hold_twid_d;

  logic                    eoff;
  logic [15:0]             head_lo;
  logic [15:0]             head_hi;
  logic [31:0]             head_pc_hi;

  assign fetch_rdy_o    = !full && !flush_i;
  assign unused_pc_bit0 = fetch_pc_i[0];

  always_comb begin
    push_entry         = '0;
    push_entry.data    = fetch_data_i;
    push_entry.pc      = {fetch_pc_i[31:2], 2'b00};
    push_entry.twid    = fetch_twid_i;
    push_entry.skip_lo = fetch_pc_i[1];
  end

  mrv1_fetch_fifo #(
    .DEPTH_P(DEPTH_P)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .push_i     (fetch_vld_i && fetch_rdy_o),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign eoff       = off_q | head.skip_lo;
  assign head_lo    = head.data[15:0];
  assign head_hi    = head.data[31:16];
  assign head_pc_hi = head.pc + 32'd2;

  always_comb begin
    off_d       = off_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_pc_d   = hold_pc_q;
    hold_twid_d = hold_twid_q;
    pop         = 1'b0;
    insn_vld_o  = 1'b0;
    insn_o      = '0;
    insn_pc_o   = '0;
    insn_twid_o = '0;

    if (flush_i) begin
      off_d      = 1'b0;
      hold_vld_d = 1'b0;
    end else if (!empty) begin
      if (hold_vld_q) begin
        // Complete the straddler; the upper half of head stays queued.
        insn_vld_o  = 1'b1;
        insn_o      = {head_lo, hold_data_q};
        insn_pc_o   = hold_pc_q;
        insn_twid_o = hold_twid_q;
        if (insn_rdy_i) begin
          hold_vld_d = 1'b0;
          off_d      = 1'b1;
        end
      end else if (!eoff) begin
        insn_vld_o  = 1'b1;
        insn_pc_o   = head.pc;
        insn_twid_o = head.twid;
        if (is_rv32(head_lo)) begin
          insn_o = head.data;
          if (insn_rdy_i) begin
            pop   = 1'b1;
            off_d = 1'b0;
          end
        end else begin
          insn_o = {16'h0000, head_lo};
          if (insn_rdy_i) off_d = 1'b1;
        end
      end else if (is_rv32(head_hi)) begin
        // Straddle: park the low half and retire the word; this bubble
        // happens regardless of decode backpressure.
        hold_vld_d  = 1'b1;
        hold_data_d = head_hi;
        hold_pc_d   = head_pc_hi;
        hold_twid_d = head.twid;
        pop         = 1'b1;
        off_d       = 1'b0;
      end else begin
        insn_vld_o  = 1'b1;
        insn_o      = {16'h0000, head_hi};
        insn_pc_o   = head_pc_hi;
        insn_twid_o = head.twid;
        if (insn_rdy_i) begin
          pop   = 1'b1;
          off_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q       <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_pc_q   <= '0;
      hold_twid_q <= '0;
    end else begin
      off_q       <= off_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_pc_q   <= hold_pc_d;
      hold_twid_q <= hold_twid_d;
    end
  end

endmodule

// File: tb/tb_mrv1_ifetch_align.sv
// tb/tb_mrv1_ifetch_align.sv - self-checking bench for mrv1_ifetch_align

module tb_mrv1_ifetch_align;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_vld_i = 1'b0;
  logic        fetch_rdy_o;
  logic [31:0] fetch_data_i = '0;
  logic [31:0] fetch_pc_i = '0;
  logic [1:0]  fetch_twid_i = '0;
  logic        insn_vld_o;
  logic        insn_rdy_i = 1'b0;
  logic [31:0] insn_o;
  logic [31:0] insn_pc_o;
  logic [1:0]  insn_twid_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mrv1_ifetch_align #(
    .DATA_WIDTH_P(32),
    .DEPTH_P     (4),
    .TWID_WIDTH_P(2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .fetch_vld_i (fetch_vld_i),
    .fetch_rdy_o (fetch_rdy_o),
    .fetch_data_i(fetch_data_i),
    .fetch_pc_i  (fetch_pc_i),
    .fetch_twid_i(fetch_twid_i),
    .insn_vld_o  (insn_vld_o),
    .insn_rdy_i  (insn_rdy_i),
    .insn_o      (insn_o),
    .insn_pc_o   (insn_pc_o),
    .insn_twid_o (insn_twid_o)
  );

  typedef struct {
    logic        flush;
    logic        push;
    logic [31:0] word;
    logic [31:0] pc;
    logic [1:0]  twid;
    logic        rdy;
    logic        exp_vld;
    logic        exp_frdy;
    logic [31:0] exp_insn;
    logic [31:0] exp_pc;
    logic [1:0]  exp_twid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic drive(input logic fl, input logic push, input logic [31:0] w,
                       input logic [31:0] pc, input logic [1:0] tw, input logic rdy);
    @(negedge clk);
    flush_i      = fl;
    fetch_vld_i  = push;
    fetch_data_i = w;
    fetch_pc_i   = pc;
    fetch_twid_i = tw;
    insn_rdy_i   = rdy;
    #2;
  endtask

  task automatic expect_insn(input string name, input logic [31:0] insn, input logic [31:0] pc);
    chk({name, ".vld"}, {31'd0, insn_vld_o}, 32'd1);
    chk({name, ".insn"}, insn_o, insn);
    chk({name, ".pc"}, insn_pc_o, pc);
  endtask

  function automatic vec_t mk(input logic fl, input logic push, input logic [31:0] w,
                              input logic [31:0] pc, input logic [1:0] tw, input logic rdy,
                              input logic ev, input logic ef, input logic [31:0] ei,
                              input logic [31:0] ep, input logic [1:0] et);
    vec_t v;
    v.flush = fl; v.push = push; v.word = w; v.pc = pc; v.twid = tw; v.rdy = rdy;
    v.exp_vld = ev; v.exp_frdy = ef; v.exp_insn = ei; v.exp_pc = ep; v.exp_twid = et;
    return v;
  endfunction

  initial begin
    // RV32 stream
    vecs.push_back(mk(0, 1, 32'h00100093, 32'h100, 2'd1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h00200113, 32'h104, 2'd1, 1, 1, 1, 32'h00100093, 32'h100, 2'd1));
    vecs.push_back(mk(0, 1, 32'h00300193, 32'h108, 2'd1, 1, 1, 1, 32'h00200113, 32'h104, 2'd1));
    vecs.push_back(mk(0, 1, 32'h00400213, 32'h10C, 2'd1, 1, 1, 1, 32'h00300193, 32'h108, 2'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h00400213, 32'h10C, 2'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // Paired RVC
    vecs.push_back(mk(0, 1, 32'h45854505, 32'h200, 2'd2, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h00004505, 32'h200, 2'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h00004585, 32'h202, 2'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // Straddle with one-cycle bubble
    vecs.push_back(mk(0, 1, 32'h05134505, 32'h300, 2'd3, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h45850050, 32'h304, 2'd3, 1, 1, 1, 32'h00004505, 32'h300, 2'd3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h00500513, 32'h302, 2'd3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h00004585, 32'h306, 2'd3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // Redirect: queued word and same-cycle push are dropped, resume at 0x402
    vecs.push_back(mk(0, 1, 32'h00100093, 32'h3F0, 2'd0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h00200113, 32'h3F4, 2'd0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h45854505, 32'h402, 2'd1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h00004585, 32'h402, 2'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    // Straddle across the top of the address space: PC wraps
    vecs.push_back(mk(0, 1, 32'h05134505, 32'hFFFFFFFE, 2'd2, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h45850050, 32'h00000000, 2'd2, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h00500513, 32'hFFFFFFFE, 2'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h00004585, 32'h00000002, 2'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));

    // Reset state
    #12;
    chk("reset.vld", {31'd0, insn_vld_o}, 32'd0);
    chk("reset.frdy", {31'd0, fetch_rdy_o}, 32'd1);
    chk("reset.insn", insn_o, 32'd0);
    chk("reset.pc", insn_pc_o, 32'd0);
    chk("reset.twid", {30'd0, insn_twid_o}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].push, vecs[i].word, vecs[i].pc, vecs[i].twid, vecs[i].rdy);
      chk($sformatf("v%0d.vld", i), {31'd0, insn_vld_o}, {31'd0, vecs[i].exp_vld});
      chk($sformatf("v%0d.frdy", i), {31'd0, fetch_rdy_o}, {31'd0, vecs[i].exp_frdy});
      if (vecs[i].exp_vld) begin
        chk($sformatf("v%0d.insn", i), insn_o, vecs[i].exp_insn);
        chk($sformatf("v%0d.pc", i), insn_pc_o, vecs[i].exp_pc);
        chk($sformatf("v%0d.twid", i), {30'd0, insn_twid_o}, {30'd0, vecs[i].exp_twid});
      end
    end

    // Backpressure: fill the queue with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h00100093 + (i << 20), 32'h600 + 4 * i, 2'd0, 0);
      chk($sformatf("bp.frdy%0d", i), {31'd0, fetch_rdy_o}, 32'd1);
    end
    // Queue full: a 5th word offered must be refused and not disturb order
    drive(0, 1, 32'hDEADBEEF, 32'h610, 2'd0, 0);
    chk("bp.full", {31'd0, fetch_rdy_o}, 32'd0);
    expect_insn("bp.stall0", 32'h00100093, 32'h600);
    for (int i = 1; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("bp.full%0d", i), {31'd0, fetch_rdy_o}, 32'd0);
      expect_insn($sformatf("bp.stall%0d", i), 32'h00100093, 32'h600);
    end
    drive(0, 0, 0, 0, 0, 1);
    expect_insn("bp.drain0", 32'h00100093, 32'h600);
    chk("bp.frdy_pop", {31'd0, fetch_rdy_o}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      if (i == 1) chk("bp.frdy_after_pop", {31'd0, fetch_rdy_o}, 32'd1);
      expect_insn($sformatf("bp.drain%0d", i), 32'h00100093 + (i << 20), 32'h600 + 4 * i);
    end
    drive(0, 0, 0, 0, 0, 1);
    chk("bp.empty", {31'd0, insn_vld_o}, 32'd0);

    // Flush while the low half of a straddler is held
    drive(0, 1, 32'h05134505, 32'h702, 2'd1, 1);
    chk("fh.push", {31'd0, insn_vld_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    chk("fh.load", {31'd0, insn_vld_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    chk("fh.wait", {31'd0, insn_vld_o}, 32'd0);
    drive(1, 0, 0, 0, 0, 1);
    chk("fh.flush", {31'd0, insn_vld_o}, 32'd0);
    drive(0, 1, 32'h00100093, 32'h500, 2'd2, 1);
    chk("fh.newpush", {31'd0, insn_vld_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    expect_insn("fh.out", 32'h00100093, 32'h500);
    chk("fh.twid", {30'd0, insn_twid_o}, 32'd2);
    drive(0, 0, 0, 0, 0, 1);
    chk("fh.empty", {31'd0, insn_vld_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
